// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the BRAM port arbiter.
package bram_arb_pkg;

   localparam int NREQ_MAX = 4;

   // One read-tracking entry: a live bit plus the one-hot requester id.
   typedef struct packed {
      logic                valid;
      logic [NREQ_MAX-1:0] id;
   } rd_tag_t;

   // Read latency of the BRAM A port: one cycle, plus one for the output register.
   function automatic int rd_lat(input int do_reg);
      return 1 + do_reg;
   endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from rr_ptr, with wrap.
module rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt
);

   localparam int               PTR_W  = (NREQ > 2) ? 2 : 1;
   localparam logic [PTR_W:0]   NREQ_W = (PTR_W+1)'(NREQ);

   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   logic [PTR_W-1:0]  sel;
   logic [PTR_W:0]    sum, nxt;
   logic              any;

   // Rotate requests so rr_ptr sits at bit 0, pick the lowest set bit, rotate back.
   always_comb begin
      dbl      = {req, req} >> rr_ptr_q;
      rot      = dbl[NREQ-1:0];
      any      = (|req) & ~rst;
      sel      = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         if (rot[i]) sel = PTR_W'(i);
      end
      sum = {1'b0, sel} + {1'b0, rr_ptr_q};
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      nxt = sum + 1'b1;
      if (nxt == NREQ_W) nxt = '0;
      gnt = '0;
      if (any) gnt[sum[PTR_W-1:0]] = 1'b1;
      rr_ptr_d = any ? nxt[PTR_W-1:0] : rr_ptr_q;
   end

   // Pointer moves past the winner; holds when nothing is granted.
   always_ff @(posedge clk) begin
      if (rst) rr_ptr_q <= '0;
      else     rr_ptr_q <= rr_ptr_d;
   end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM A port among NREQ requesters; routes read data back by tag.
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16,
   parameter int DO_REG = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ-1:0]        req_we,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   bram_en,
   output logic [1:0]             bram_we,
   output logic [ADDR_W-1:0]      bram_addr,
   output logic [DATA_W-1:0]      bram_wdata,
   output logic                   bram_regce,
   input  logic [DATA_W-1:0]      bram_rdata
);

   localparam int RD_LAT = rd_lat(DO_REG);

   if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
      $error("bram_port_arbiter: NREQ must be 2..4");
   end
   if (DO_REG < 0 || DO_REG > 1) begin : g_bad_do_reg
      $error("bram_port_arbiter: DO_REG must be 0 or 1");
   end

   logic [NREQ-1:0]             gnt;
   logic                        we_g;
   rd_tag_t [RD_LAT-1:0]        tag_q, tag_d;
   rd_tag_t                     tag_out;
   logic                        unused_tag_bits;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk (clk),
      .rst (rst),
      .req (req_valid),
      .gnt (gnt)
   );

   assign req_ready = gnt;

   // Issue mux: grant is one-hot, so OR-ing the masked requester fields selects it.
   always_comb begin
      bram_addr  = '0;
      bram_wdata = '0;
      we_g       = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            bram_addr  = bram_addr  | req_addr[i*ADDR_W +: ADDR_W];
            bram_wdata = bram_wdata | req_wdata[i*DATA_W +: DATA_W];
            we_g       = we_g | req_we[i];
         end
      end
      bram_en = |gnt;
      bram_we = {2{we_g}};
   end

   // Read-tag shift pipe: stage 0 loads on acceptance, last stage lines up with DOADO.
   always_comb begin
      tag_d          = tag_q;
      tag_d[0].valid = (|gnt) & ~we_g;
      tag_d[0].id    = NREQ_MAX'(gnt);
      for (int s = 1; s < RD_LAT; s++) begin
         tag_d[s] = tag_q[s-1];
      end
   end

   // Reset drops every in-flight read.
   always_ff @(posedge clk) begin
      if (rst) tag_q <= '0;
      else     tag_q <= tag_d;
   end

   // Response demux; the output register only loads for tracked reads.
   always_comb begin
      tag_out         = tag_q[RD_LAT-1];
      rsp_valid       = tag_out.valid ? tag_out.id[NREQ-1:0] : '0;
      rsp_rdata       = tag_out.valid ? bram_rdata : '0;
      bram_regce      = (DO_REG == 1) ? tag_q[0].valid : 1'b0;
      unused_tag_bits = ^tag_out.id;
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized + directed bench for bram_port_arbiter with a behavioural BRAM and reference model.
module tb_bram_port_arbiter;

   localparam int NREQ   = 4;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 16;
   localparam int DO_REG = 1;
   localparam int RD_LAT = 1 + DO_REG;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NREQ-1:0]        req_valid, req_ready, req_we, rsp_valid;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_wdata;
   logic [DATA_W-1:0]      rsp_rdata, bram_wdata, bram_rdata;
   logic                   bram_en, bram_regce;
   logic [1:0]             bram_we;
   logic [ADDR_W-1:0]      bram_addr;

   always #5 clk = ~clk;

   bram_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DO_REG(DO_REG)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
      .bram_regce(bram_regce), .bram_rdata(bram_rdata)
   );

   // Behavioural BRAM A port, WRITE_FIRST, optional output register.
   logic [DATA_W-1:0] mem [1<<ADDR_W];
   logic [DATA_W-1:0] dlat, dreg;
   always @(posedge clk) begin
      if (bram_en) begin
         if (|bram_we) begin
            mem[bram_addr] <= bram_wdata;
            dlat           <= bram_wdata;
         end else begin
            dlat <= mem[bram_addr];
         end
      end
      if (bram_regce) dreg <= dlat;
   end
   assign bram_rdata = (DO_REG == 1) ? dreg : dlat;

   // Reference model state
   typedef struct { int due; int id; logic [DATA_W-1:0] data; } exp_t;
   exp_t              q[$];
   logic [DATA_W-1:0] ref_mem [1<<ADDR_W];
   int ptr, cyc, mode, last_g;
   int n_chk, n_pass;
   // Observations for directed checks
   logic [NREQ-1:0]   seen_mask, obs_ready;
   logic [DATA_W-1:0] seen_data;
   int                seen_cyc, acc_cyc;
   logic              quiet_or;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic set_req(input int i, input bit v, input bit we, input int a, input int d);
      req_valid[i]                  = v;
      req_we[i]                     = we;
      req_addr[i*ADDR_W +: ADDR_W]  = a[ADDR_W-1:0];
      req_wdata[i*DATA_W +: DATA_W] = d[DATA_W-1:0];
   endtask

   task automatic rand_req(input int i, input bit v);
      set_req(i, v, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom));
   endtask

   function automatic int exp_grant();
      if (rst) return -1;
      for (int off = 0; off < NREQ; off++) begin
         if (req_valid[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
      end
      return -1;
   endfunction

   task automatic clr_seen();
      seen_mask = '0; seen_data = '0; seen_cyc = -1; quiet_or = 1'b0;
   endtask

   // One clock: check outputs at negedge, advance model at posedge, update drivers after.
   task automatic cycle();
      int                g;
      logic [NREQ-1:0]   er, ev;
      logic [DATA_W-1:0] ed;
      logic              ereg;
      int                a;
      g  = exp_grant();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      @(negedge clk);
      chk("ready", 32'(req_ready), 32'(er));
      chk("en", 32'(bram_en), 32'(g >= 0));
      if (g >= 0) begin
         chk("addr",  32'(bram_addr),  32'(req_addr[g*ADDR_W +: ADDR_W]));
         chk("wdata", 32'(bram_wdata), 32'(req_wdata[g*DATA_W +: DATA_W]));
         chk("we",    32'(bram_we),    32'({2{req_we[g]}}));
      end else begin
         chk("addr_idle", 32'(bram_addr), 0);
         chk("we_idle",   32'(bram_we),   0);
      end
      if (!rst) begin
         ev = '0; ed = '0; ereg = 1'b0;
         if (q.size() > 0 && q[0].due == cyc) begin
            ev[q[0].id] = 1'b1;
            ed          = q[0].data;
         end
         foreach (q[k]) if (DO_REG == 1 && q[k].due == cyc + 1) ereg = 1'b1;
         chk("rsp_valid", 32'(rsp_valid),  32'(ev));
         chk("rsp_rdata", 32'(rsp_rdata),  32'(ed));
         chk("regce",     32'(bram_regce), 32'(ereg));
         if (rsp_valid != '0) begin
            seen_mask = seen_mask | rsp_valid;
            seen_data = rsp_rdata;
            seen_cyc  = cyc;
         end
      end
      obs_ready = req_ready;
      quiet_or  = quiet_or | bram_en | bram_regce | (|rsp_valid);
      @(posedge clk);
      while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
      if (rst) begin
         ptr = 0;
         q.delete();
      end else if (g >= 0) begin
         ptr     = (g + 1) % NREQ;
         acc_cyc = cyc;
         a       = int'(req_addr[g*ADDR_W +: ADDR_W]);
         if (req_we[g]) ref_mem[a] = req_wdata[g*DATA_W +: DATA_W];
         else           q.push_back('{cyc + RD_LAT, g, ref_mem[a]});
      end
      last_g = g;
      cyc++;
      #1;
      if (mode == 2) begin
         if (g >= 0) rand_req(g, 1'($urandom_range(0, 1)));
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) rand_req(i, 1'b1);
         end
      end else if (mode == 0 && g >= 0) begin
         req_valid[g] = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   int cnt [NREQ];
   int ptr_save;

   initial begin
      n_chk = 0; n_pass = 0; cyc = 0; ptr = 0; mode = 0; last_g = -1;
      for (int i = 0; i < (1 << ADDR_W); i++) begin
         mem[i] = '0; ref_mem[i] = '0;
      end
      dlat = '0; dreg = '0;
      req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      clr_seen();
      rst = 1'b1;
      @(posedge clk); #1;
      idle(2);
      rst = 1'b0;
      idle(1);

      // Single requester: write 0x1234 @5, then read it back
      set_req(0, 1, 1, 5, 'h1234);
      cycle();
      set_req(0, 1, 0, 5, 0);
      clr_seen();
      cycle();
      idle(RD_LAT + 1);
      chk("single_data", 32'(seen_data), 32'h1234);
      chk("single_id",   32'(seen_mask), 32'h1);
      chk("single_lat",  32'(seen_cyc - acc_cyc), 32'(RD_LAT));

      // Contention: from a fresh pointer, req0/req1 hold reads for 6 cycles
      rst = 1'b1; idle(1); rst = 1'b0;
      mode = 1;
      set_req(0, 1, 0, 5, 0);
      set_req(1, 1, 0, 7, 0);
      for (int k = 0; k < 6; k++) begin
         cycle();
         chk($sformatf("cont_g%0d", k), 32'(last_g), 32'(k % 2));
      end
      req_valid = '0;
      idle(RD_LAT + 1);

      // Starvation: all four valid, each granted once per 4-cycle window
      for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, i, 0);
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < NREQ; i++) cnt[i] = 0;
         for (int k = 0; k < NREQ; k++) begin
            cycle();
            if (last_g >= 0) cnt[last_g]++;
         end
         for (int i = 0; i < NREQ; i++) chk($sformatf("starve_w%0d_r%0d", w, i), 32'(cnt[i]), 1);
      end
      mode = 0;
      req_valid = '0;
      idle(RD_LAT + 1);

      // req1 writes 0xBEEF @0x3FF, req0 reads it the next cycle
      set_req(1, 1, 1, 'h3FF, 'hBEEF);
      cycle();
      set_req(0, 1, 0, 'h3FF, 0);
      clr_seen();
      cycle();
      idle(RD_LAT + 1);
      chk("wrap_data", 32'(seen_data), 32'hBEEF);
      chk("wrap_id",   32'(seen_mask), 32'h1);

      // Idle: nothing moves, pointer holds
      ptr_save = ptr;
      clr_seen();
      idle(10);
      chk("idle_quiet", 32'(quiet_or), 0);
      req_valid = '1;
      cycle();
      chk("idle_ptr_hold", 32'(obs_ready), 32'(1 << ptr_save));
      req_valid = '0;
      idle(RD_LAT + 1);

      // Reset with a read in flight: the response is dropped, pointer returns to 0
      set_req(2, 1, 0, 5, 0);
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      clr_seen();
      idle(RD_LAT + 1);
      chk("rst_drop", 32'(seen_mask), 0);
      req_valid = '1;
      cycle();
      chk("rst_ptr", 32'(obs_ready), 32'h1);
      req_valid = '0;
      idle(RD_LAT + 1);

      // Random traffic against the reference model
      mode = 2;
      for (int i = 0; i < NREQ; i++) rand_req(i, 1'($urandom_range(0, 1)));
      idle(400);
      mode = 0;
      req_valid = '0;
      idle(RD_LAT + 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
